// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Accepts one pair of SIZE x SIZE 8-bit operand matrices and streams them into
//   a systolic array as diagonally skewed lanes. Lane i of A carries row i and is
//   delayed by i cycles. Lane j of B carries column j and is delayed by j cycles.
//   Feeding takes 2*SIZE-1 cycles. The outputs then stay quiet for DRAIN_CYCLES
//   cycles so the array can finish, and done pulses for one cycle.
//
// Parameters
//   SIZE          array dimension (operand matrices are SIZE x SIZE)
//   DRAIN_CYCLES  idle cycles between the last operand and done
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   in_valid  matrix pair offered on a_mat/b_mat
//   in_ready  high only while idle; a transfer happens when in_valid && in_ready
//   a_mat     operand A, a_mat[row][k]
//   b_mat     operand B, b_mat[k][col] (b_mat[col][k] with FEEDER_TRANSPOSE_B_EN)
//   a_in      skewed A lane per array row, qualified by valid_a
//   b_in      skewed B lane per array column, qualified by valid_b
//   busy      high while feeding or draining
//   done      one-cycle pulse once the multiply has drained
//
// Build option
//   FEEDER_TRANSPOSE_B_EN  when defined, b_mat is read as B transposed.
module systolic_feeder #(
  parameter int SIZE         = 4,
  parameter int DRAIN_CYCLES = 2 * SIZE,
  localparam int DATA_W      = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]   a_mat,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0]   b_mat,
  output logic [SIZE-1:0][DATA_W-1:0]             a_in,
  output logic [SIZE-1:0]                         valid_a,
  output logic [SIZE-1:0][DATA_W-1:0]             b_in,
  output logic [SIZE-1:0]                         valid_b,
  output logic                                    busy,
  output logic                                    done
);

  localparam int T_LAST_I = 2 * SIZE - 2;
  localparam int CNT_MAX  = (T_LAST_I > DRAIN_CYCLES) ? T_LAST_I : DRAIN_CYCLES;
  localparam int CW       = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int IW       = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [CW-1:0] T_LAST = CW'(T_LAST_I);
  localparam logic [CW-1:0] D_LAST = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                                state;
  logic [CW-1:0]                         t_cnt;
  logic [CW-1:0]                         drain_cnt;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_buf;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_buf;

  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] a_src;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] b_src;
  logic [CW-1:0]                         t_nxt;
  logic [SIZE-1:0][DATA_W-1:0]           a_lane_p0;
  logic [SIZE-1:0][DATA_W-1:0]           b_lane_p0;
  logic [SIZE-1:0]                       vld_a_p0;
  logic [SIZE-1:0]                       vld_b_p0;
  int                                    k;

  // ---- stage p0: lane values for the feed step about to be registered ----
  // At the transfer edge the buffers are not loaded yet, so step t=0 is taken
  // straight from the input matrices. Every later step reads the buffers.
  always_comb begin
    a_src     = (state == IDLE) ? a_mat : a_buf;
    b_src     = (state == IDLE) ? b_mat : b_buf;
    t_nxt     = (state == IDLE) ? '0 : t_cnt + CW'(1);
    a_lane_p0 = '0;
    b_lane_p0 = '0;
    vld_a_p0  = '0;
    vld_b_p0  = '0;
    k         = 0;
    for (int i = 0; i < SIZE; i++) begin
      k = int'(t_nxt) - i;
      if (k >= 0 && k < SIZE) begin
        vld_a_p0[i]  = 1'b1;
        vld_b_p0[i]  = 1'b1;
        a_lane_p0[i] = a_src[i][IW'(k)];
`ifdef FEEDER_TRANSPOSE_B_EN
        b_lane_p0[i] = b_src[i][IW'(k)];
`else
        b_lane_p0[i] = b_src[IW'(k)][i];
`endif
      end
    end
  end

  // Operand buffers load only on a transfer. They stay frozen for the rest of the
  // operation.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_buf <= a_mat;
      b_buf <= b_mat;
    end
  end

  // ---- stage p1: control FSM and registered lane outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      t_cnt     <= '0;
      drain_cnt <= '0;
      a_in      <= '0;
      b_in      <= '0;
      valid_a   <= '0;
      valid_b   <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= FEED;
            t_cnt    <= '0;
            a_in     <= a_lane_p0;
            b_in     <= b_lane_p0;
            valid_a  <= vld_a_p0;
            valid_b  <= vld_b_p0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FEED: begin
          if (t_cnt == T_LAST) begin
            a_in      <= '0;
            b_in      <= '0;
            valid_a   <= '0;
            valid_b   <= '0;
            drain_cnt <= '0;
            if (DRAIN_CYCLES == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            t_cnt   <= t_nxt;
            a_in    <= a_lane_p0;
            b_in    <= b_lane_p0;
            valid_a <= vld_a_p0;
            valid_b <= vld_b_p0;
          end
        end
        DRAIN: begin
          if (drain_cnt == D_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + CW'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int SIZE = 4;

  typedef logic [SIZE-1:0][SIZE-1:0][7:0] mat_t;

  logic                  clk;
  logic                  reset;
  logic                  in_valid;
  logic                  in_valid0;
  mat_t                  a_mat;
  mat_t                  b_mat;

  logic                  in_ready,  busy,  done;
  logic [SIZE-1:0][7:0]  a_in,  b_in;
  logic [SIZE-1:0]       valid_a, valid_b;

  logic                  in_ready0, busy0, done0;
  logic [SIZE-1:0][7:0]  a_in0, b_in0;
  logic [SIZE-1:0]       valid_a0, valid_b0;

  mat_t                  ma;  // logical A[row][k]
  mat_t                  mb;  // logical B[k][col]

  int n_vec  = 0;
  int n_miss = 0;

  systolic_feeder #(.SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_mat(a_mat), .b_mat(b_mat), .a_in(a_in), .valid_a(valid_a),
    .b_in(b_in), .valid_b(valid_b), .busy(busy), .done(done)
  );

  systolic_feeder #(.SIZE(SIZE), .DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .a_mat(a_mat), .b_mat(b_mat), .a_in(a_in0), .valid_a(valid_a0),
    .b_in(b_in0), .valid_b(valid_b0), .busy(busy0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic mat_t mk_ramp(input logic [7:0] base);
    mat_t m;
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        m[r][c] = 8'(int'(base) + 16 * r + c);
    return m;
  endfunction

  function automatic mat_t mk_ident();
    mat_t m;
    m = '0;
    for (int r = 0; r < SIZE; r++) m[r][r] = 8'h01;
    return m;
  endfunction

  // Drive the ports with logical A/B (B is laid out transposed when that build option is on).
  task automatic drive(input mat_t a, input mat_t b);
    a_mat = a;
`ifdef FEEDER_TRANSPOSE_B_EN
    for (int k = 0; k < SIZE; k++)
      for (int j = 0; j < SIZE; j++)
        b_mat[j][k] = b[k][j];
`else
    b_mat = b;
`endif
  endtask

  task automatic apply(input mat_t a, input mat_t b);
    ma = a;
    mb = b;
    drive(a, b);
  endtask

  // Called on the sample just after the transfer edge (cycle 1). Checks cycles 1..17
  // of one operation on the default-drain instance and ends at the cycle-17 sample.
  task automatic run_op(input bit hand);
    logic [SIZE-1:0][7:0] ea, eb;
    logic [SIZE-1:0]      eva, evb;
    int                   t;
    int                   cnt_a[SIZE], cnt_b[SIZE], first_a[SIZE], first_b[SIZE];
    for (int i = 0; i < SIZE; i++) begin
      cnt_a[i] = 0; cnt_b[i] = 0; first_a[i] = -1; first_b[i] = -1;
    end
    for (int cyc = 1; cyc <= 17; cyc++) begin
      t   = cyc - 1;
      ea  = '0; eb = '0; eva = '0; evb = '0;
      if (cyc <= 2 * SIZE - 1) begin
        for (int i = 0; i < SIZE; i++) begin
          if (t - i >= 0 && t - i < SIZE) begin
            eva[i] = 1'b1;
            evb[i] = 1'b1;
            ea[i]  = ma[i][t - i];
            eb[i]  = mb[t - i][i];
          end
        end
      end
      check_val($sformatf("valid_a c%0d", cyc), 64'(valid_a), 64'(eva));
      check_val($sformatf("valid_b c%0d", cyc), 64'(valid_b), 64'(evb));
      check_val($sformatf("a_in c%0d", cyc), 64'(a_in), 64'(ea));
      check_val($sformatf("b_in c%0d", cyc), 64'(b_in), 64'(eb));
      check_val($sformatf("busy c%0d", cyc), 64'(busy), 64'(cyc <= 15));
      check_val($sformatf("done c%0d", cyc), 64'(done), 64'(cyc == 16));
      check_val($sformatf("in_ready c%0d", cyc), 64'(in_ready), 64'(cyc == 17));
      if (hand) begin
        if (cyc == 1) check_val("hand va t0", 64'(valid_a), 64'(4'b0001));
        if (cyc == 4) check_val("hand va0 t3", 64'(valid_a[0]), 64'(1));
        if (cyc == 5) check_val("hand va0 t4", 64'(valid_a[0]), 64'(0));
        if (cyc == 5) check_val("hand b2 t4", 64'(b_in[2]), 64'(8'h22));
        if (cyc == 7) check_val("hand va t6", 64'(valid_a), 64'(4'b1000));
        if (cyc == 16) check_val("hand done", 64'(done), 64'(1));
      end
      for (int i = 0; i < SIZE; i++) begin
        if (valid_a[i]) begin
          if (first_a[i] < 0) first_a[i] = t;
          cnt_a[i]++;
        end
        if (valid_b[i]) begin
          if (first_b[i] < 0) first_b[i] = t;
          cnt_b[i]++;
        end
      end
      if (cyc < 17) step();
    end
    for (int i = 0; i < SIZE; i++) begin
      check_val($sformatf("cnt_a lane%0d", i), 64'(cnt_a[i]), 64'(SIZE));
      check_val($sformatf("cnt_b lane%0d", i), 64'(cnt_b[i]), 64'(SIZE));
      check_val($sformatf("first_a lane%0d", i), 64'(first_a[i]), 64'(i));
      check_val($sformatf("first_b lane%0d", i), 64'(first_b[i]), 64'(i));
    end
  endtask

  initial begin
    bit saw_done;
    logic [SIZE-1:0][7:0] eb0;
    int t;

    reset = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
    a_mat = '0; b_mat = '0; ma = '0; mb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst in_ready", 64'(in_ready), 64'(1));
    check_val("rst busy", 64'(busy), 64'(0));
    check_val("rst done", 64'(done), 64'(0));
    check_val("rst valid", 64'({valid_a, valid_b}), 64'(0));
    check_val("rst data", 64'({a_in, b_in}), 64'(0));
    reset = 1'b1;
    step();

    // Identity A, ramp B, single transfer
    apply(mk_ident(), mk_ramp(8'h00));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_op(1'b1);

    // All-0xFF operands
    apply('1, '1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_op(1'b0);

    // in_valid held high; inputs change mid-operation and become the second pair
    apply(mk_ramp(8'h10), mk_ramp(8'h00));
    in_valid = 1'b1;
    step();
    drive(mk_ramp(8'h80), mk_ramp(8'h40));
    run_op(1'b0);
    ma = mk_ramp(8'h80);
    mb = mk_ramp(8'h40);
    step();
    in_valid = 1'b0;
    run_op(1'b0);

    // Reset pulsed low while t=3 is presented
    apply(mk_ident(), mk_ramp(8'h00));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check_val("pre-abort va", 64'(valid_a), 64'(4'b1111));
    #2 reset = 1'b0;
    #1;
    check_val("abort async data", 64'({a_in, b_in}), 64'(0));
    check_val("abort async valid", 64'({valid_a, valid_b}), 64'(0));
    check_val("abort async ready", 64'(in_ready), 64'(1));
    check_val("abort async busy", 64'(busy), 64'(0));
    step();
    check_val("abort held valid", 64'({valid_a, valid_b}), 64'(0));
    check_val("abort held ready", 64'(in_ready), 64'(1));
    reset = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    check_val("abort no done", 64'(saw_done), 64'(0));
    check_val("abort idle ready", 64'(in_ready), 64'(1));
    apply(mk_ident(), mk_ramp(8'h00));
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    run_op(1'b1);

    // Zero drain: done in the cycle right after t=6
    apply(mk_ramp(8'h20), mk_ramp(8'h00));
    in_valid0 = 1'b1;
    step();
    in_valid0 = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      t   = cyc - 1;
      eb0 = '0;
      if (cyc <= 2 * SIZE - 1)
        for (int j = 0; j < SIZE; j++)
          if (t - j >= 0 && t - j < SIZE) eb0[j] = mb[t - j][j];
      check_val($sformatf("d0 b_in c%0d", cyc), 64'(b_in0), 64'(eb0));
      check_val($sformatf("d0 busy c%0d", cyc), 64'(busy0), 64'(cyc <= 7));
      check_val($sformatf("d0 done c%0d", cyc), 64'(done0), 64'(cyc == 8));
      check_val($sformatf("d0 ready c%0d", cyc), 64'(in_ready0), 64'(cyc == 9));
      if (cyc < 9) step();
    end
    check_val("d0 hand b2 t4 idle", 64'(b_in0[2]), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
